// File: rtl/uart_pkg.sv
// Shared constants for the UART command parser: frame markers, error codes,
// LED command values and the parser state encoding.
package uart_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] LED_CMD_ID = 8'h01;
    localparam logic [7:0] LED_ON_VAL = 8'h1F;
    localparam logic [7:0] LED_OFF_VAL = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_CMD = 3'd1,
        ST_GET_LEN = 3'd2,
        ST_GET_PAY = 3'd3,
        ST_GET_CHK = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // A payload length is acceptable when it is non-zero and fits the buffer.
    function automatic logic pay_len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream in / decoded-command out bundle around the UART command parser.
interface uart_cmd_parser_if #(
    parameter int MAX_LEN = 8
);
    logic                   rx_datav;
    logic [7:0]             rx_byte;
    logic                   cmd_valid;
    logic [7:0]             cmd_id;
    logic [3:0]             cmd_len;
    logic [8*MAX_LEN-1:0]   cmd_payload;
    logic                   err;
    logic [1:0]             err_code;
    logic                   led;

    modport master (
        output rx_datav, rx_byte,
        input  cmd_valid, cmd_id, cmd_len, cmd_payload, err, err_code, led
    );

    modport slave (
        input  rx_datav, rx_byte,
        output cmd_valid, cmd_id, cmd_len, cmd_payload, err, err_code, led
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses SOF/CMD/LEN/payload/CHK frames from a received byte stream and reports
// good commands, framing errors and the LED state driven by command 0x01.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int MAX_LEN      = 8,
    parameter int TIMEOUT_CLKS = 86800
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rx_datav_in,
    input  logic [7:0]           rx_byte_in,
    output logic                 cmd_valid_op,
    output logic [7:0]           cmd_id_op,
    output logic [3:0]           cmd_len_op,
    output logic [8*MAX_LEN-1:0] cmd_payload_op,
    output logic                 err_op,
    output logic [1:0]           err_code_op,
    output logic                 led_op
);

    localparam int TMO_W = ($clog2(TIMEOUT_CLKS) > 0) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e               state_q;
    logic [3:0]           idx_q;
    logic [3:0]           len_q;
    logic [7:0]           cmd_q;
    logic [7:0]           xor_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [8*MAX_LEN-1:0] pay_q;

    logic                 cmd_valid_q;
    logic [7:0]           cmd_id_q;
    logic [3:0]           cmd_len_q;
    logic [8*MAX_LEN-1:0] cmd_payload_q;
    logic                 err_q;
    logic [1:0]           err_code_q;
    logic                 led_q;

    logic [7:0]           xor_d;

    assign xor_d = xor_q ^ rx_byte_in;

    // Frame parser FSM with inter-byte timeout and registered result outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            idx_q         <= 4'd0;
            len_q         <= 4'd0;
            cmd_q         <= 8'h00;
            xor_q         <= 8'h00;
            tmo_q         <= '0;
            pay_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_id_q      <= 8'h00;
            cmd_len_q     <= 4'd0;
            cmd_payload_q <= '0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            led_q         <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;

            // The timeout only runs while a frame is partially received.
            if (rx_datav_in || state_q == ST_IDLE || state_q == ST_DONE) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (state_q == ST_DONE) begin
                state_q <= ST_IDLE;
            end else if (rx_datav_in) begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx_byte_in == SOF_BYTE) begin
                            state_q <= ST_GET_CMD;
                            xor_q   <= 8'h00;
                            idx_q   <= 4'd0;
                            pay_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_GET_CMD: begin
                        cmd_q   <= rx_byte_in;
                        xor_q   <= xor_d;
                        state_q <= ST_GET_LEN;
                    end
                    ST_GET_LEN: begin
                        xor_q <= xor_d;
                        len_q <= rx_byte_in[3:0];
                        if (rx_byte_in == 8'h00) begin
                            state_q <= ST_GET_CHK;
                        end else if (pay_len_ok(rx_byte_in, MAX_LEN_B)) begin
                            state_q <= ST_GET_PAY;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_LEN;
                            state_q    <= ST_IDLE;
                        end
                    end
                    ST_GET_PAY: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx_q == 4'(i)) begin
                                pay_q[8*i +: 8] <= rx_byte_in;
                            end
                        end
                        xor_q <= xor_d;
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == len_q - 4'd1) begin
                            state_q <= ST_GET_CHK;
                        end else begin
                            state_q <= ST_GET_PAY;
                        end
                    end
                    ST_GET_CHK: begin
                        if (rx_byte_in == xor_q) begin
                            state_q       <= ST_DONE;
                            cmd_valid_q   <= 1'b1;
                            cmd_id_q      <= cmd_q;
                            cmd_len_q     <= len_q;
                            cmd_payload_q <= pay_q;
                            if (cmd_q == LED_CMD_ID && len_q != 4'd0) begin
                                if (pay_q[7:0] == LED_ON_VAL) begin
                                    led_q <= 1'b1;
                                end else if (pay_q[7:0] == LED_OFF_VAL) begin
                                    led_q <= 1'b0;
                                end else begin
                                    led_q <= led_q;
                                end
                            end else begin
                                led_q <= led_q;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CHK;
                            state_q    <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TMO;
                state_q    <= ST_IDLE;
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign cmd_valid_op   = cmd_valid_q;
    assign cmd_id_op      = cmd_id_q;
    assign cmd_len_op     = cmd_len_q;
    assign cmd_payload_op = cmd_payload_q;
    assign err_op         = err_q;
    assign err_code_op    = err_code_q;
    assign led_op         = led_q;

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, giving the maximum payload bytes per frame (1..8).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 86800, giving the inter-byte timeout in clocks (10 byte times at 115200 baud, 100 MHz).
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_in, input, 1, the reset, which is synchronous and active-high.
REQ-005 SHALL have port rx_datav_in, input, 1, a one-cycle strobe marking a received byte.
REQ-006 SHALL have port rx_byte_in, input, 8, the received byte, valid when rx_datav_in=1.
REQ-007 SHALL have port cmd_valid_op, output, 1, a one-cycle pulse marking a good frame.
REQ-008 SHALL have port cmd_id_op, output, 8, the command byte of the last good frame.
REQ-009 SHALL have port cmd_len_op, output, 4, the payload length of the last good frame.
REQ-010 SHALL have port cmd_payload_op, output, 8*MAX_LEN, the payload; byte i occupies bits [8i+7:8i].
REQ-011 SHALL have port err_op, output, 1, a one-cycle pulse marking a frame error.
REQ-012 SHALL have port err_code_op, output, 2, the error cause: 01 bad length, 10 checksum, 11 timeout.
REQ-013 SHALL have port led_op, output, 1, the LED state set by command 0x01.

Function
REQ-014 SHALL parse the frame format SOF(0xA5), CMD, LEN, LEN payload bytes, CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-015 SHALL use states IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CHK and DONE; a state advances only on a cycle with rx_datav_in=1.
REQ-016 SHALL, in IDLE, move to GET_CMD on byte 0xA5 and ignore every other byte.
REQ-017 SHALL, in GET_LEN, go to GET_CHK on LEN=0, to GET_PAY on 1<=LEN<=MAX_LEN, and otherwise pulse err_op with code 01 and return to IDLE.
REQ-018 SHALL, in GET_PAY, store the byte at the payload index and increment the index, going to GET_CHK after byte LEN-1.
REQ-019 SHALL keep a running XOR with an 8-bit width, cleared on entry to GET_CMD.
REQ-020 SHALL, in GET_CHK, go to DONE when the byte equals the running XOR, and otherwise pulse err_op with code 10 and return to IDLE.
REQ-021 SHALL, in DONE, pulse cmd_valid_op for exactly one cycle, update cmd_id_op, cmd_len_op and cmd_payload_op in that same cycle, and return to IDLE the next cycle.
REQ-022 SHALL zero the unused payload bytes (index >= LEN) in cmd_payload_op.
REQ-023 SHALL hold cmd_id_op, cmd_len_op and cmd_payload_op stable between good frames; errors do not alter them.
REQ-024 SHALL give a latency of 1 cycle from the CHK strobe to cmd_valid_op and 1 cycle from an offending strobe to err_op.
REQ-025 SHALL, in any state other than IDLE or DONE, count clocks since the last strobe, and when the count reaches TIMEOUT_CLKS-1 with no strobe, pulse err_op with code 11 and return to IDLE.
REQ-026 SHALL, when a strobe coincides with timeout expiry, accept the byte and not fire the timeout.
REQ-027 SHALL, on a good frame with CMD=0x01 and LEN>=1, set led_op to 1 when payload[0]=0x1F and to 0 when payload[0]=0x0F, and leave it unchanged for other values.
REQ-028 SHALL drop a strobe that arrives in DONE, because the block is never back-pressured.
REQ-029 SHALL never assert cmd_valid_op and err_op in the same cycle.
REQ-030 SHALL hold err_code_op at its last value between error pulses.

Reset
REQ-031 SHALL, on rst_in=1 at a clock edge, set the state to IDLE and clear cmd_valid_op, err_op, err_code_op, cmd_id_op, cmd_len_op, cmd_payload_op, led_op, the timeout counter, the index and the XOR to 0.
REQ-032 SHALL discard any partial frame on reset mid-frame, with no error pulse.
REQ-033 SHALL ignore rx_datav_in while rst_in=1.

Structure
REQ-034 SHALL take the SOF value, the error codes, the LED command ID and the LED on/off byte values from a shared package/include, uart_pkg.
REQ-035 SHALL need no sub-module; the timeout counter is inline.

Verification
REQ-036 SHALL cover a good LED frame: A5 01 01 1F 1F -> cmd_valid_op=1 for 1 cycle, cmd_id_op=01, cmd_len_op=1, payload byte0=1F, led_op=1; then A5 01 01 0F 0F -> led_op=0.
REQ-037 SHALL cover a checksum error: A5 02 02 11 22 00 -> err_op pulse with code 10, cmd_* unchanged, no cmd_valid_op.
REQ-038 SHALL cover a bad length: A5 03 09 (MAX_LEN=8) -> err_op with code 01 one cycle after the 09 strobe; a following A5 05 00 05 -> cmd_valid_op=1 with cmd_len_op=0.
REQ-039 SHALL cover a timeout: A5 04 then no strobe for TIMEOUT_CLKS cycles -> err_op with code 11 and state IDLE; a strobe exactly at expiry -> no error.
REQ-040 SHALL cover noise and reset: bytes 00 FF 5A before A5 are ignored; rst_in asserted after A5 07 -> no outputs, and the next full frame parses correctly.
